// File: rtl/adder_bank_ctrl.sv
// adder_bank_ctrl
// Byte-serial front end for a NUM_LANES x 32-bit adder bank. Operand bytes
// stream in and land directly in the registered op_a/op_b buses. After a
// fixed settle time all lane sums are captured and streamed back out.
//
// Optional feature macro: ADDER_BANK_CTRL_CHECK_EN
//   Defined   : adds a CHECK state that recomputes every lane with one shared
//               32-bit adder and raises a sticky err on any mismatch.
//   Undefined : CAPTURE goes straight to DRAIN and err is tied low.
//
// Handshake (both streams): a byte moves on a rising edge where valid && ready
// are both high. Sources may hold valid indefinitely. While out_valid=1 and
// out_ready=0, out_byte and out_valid hold steady because both come only from
// the state register, the byte counter and the result buffer, and none of those
// move until the byte is taken.
module adder_bank_ctrl #(
   parameter int NUM_LANES     = 10,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                in_byte,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [7:0]                out_byte,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      busy,
   output logic                      err,
   output logic [NUM_LANES*32-1:0]   op_a,
   output logic [NUM_LANES*32-1:0]   op_b,
   input  logic [NUM_LANES*32-1:0]   res,
   output logic [2:0]                state_dbg
);

   localparam int W         = NUM_LANES * 32;
   localparam int IN_BYTES  = 8 * NUM_LANES;
   localparam int OUT_BYTES = 4 * NUM_LANES;
   // One counter serves every state, so it must hold both the input frame
   // length and the largest legal settle count.
   localparam int CMAX      = (IN_BYTES > 16) ? IN_BYTES : 16;
   localparam int CW        = $clog2(CMAX);

   localparam logic [CW-1:0] IN_LAST  = CW'(IN_BYTES - 1);
   localparam logic [CW-1:0] OUT_LAST = CW'(OUT_BYTES - 1);
   localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_LOAD    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_CHECK   = 3'd3,
      ST_DRAIN   = 3'd4
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] cnt;
   logic          cnt_clr;
   logic          cnt_inc;
   logic [W-1:0]  rbuf;
   logic          in_fire;
   logic          out_fire;

   assign state_dbg = state;
   assign in_fire   = in_valid && (state == ST_LOAD);
   assign out_fire  = out_ready && (state == ST_DRAIN);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_LOAD;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state, counter control and stream flags.
   always_comb begin
      state_nx  = state;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         ST_LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_fire) begin
               if (cnt == IN_LAST) begin
                  state_nx = ST_SETTLE;
                  cnt_clr  = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         ST_SETTLE: begin
            if (cnt == SET_LAST) begin
               state_nx = ST_CAPTURE;
               cnt_clr  = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_CAPTURE: begin
            cnt_clr = 1'b1;
`ifdef ADDER_BANK_CTRL_CHECK_EN
            state_nx = ST_CHECK;
`else
            state_nx = ST_DRAIN;
`endif
         end
`ifdef ADDER_BANK_CTRL_CHECK_EN
         ST_CHECK: begin
            if (cnt == CW'(NUM_LANES - 1)) begin
               state_nx = ST_DRAIN;
               cnt_clr  = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
`endif
         ST_DRAIN: begin
            out_valid = 1'b1;
            if (out_fire) begin
               if (cnt == OUT_LAST) begin
                  state_nx = ST_LOAD;
                  cnt_clr  = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         default: begin
            state_nx = ST_LOAD;
            cnt_clr  = 1'b1;
         end
      endcase
   end

   // Shared counter: input byte index, settle count, check lane, output byte index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt_clr) begin
         cnt <= '0;
      end else if (cnt_inc) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Each accepted byte goes straight into its operand slice; byte index bit 2
   // picks a or b, bits 1:0 the byte within the word, upper bits the lane.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a <= '0;
         op_b <= '0;
      end else if (in_fire) begin
         for (int l = 0; l < NUM_LANES; l++) begin
            for (int b = 0; b < 4; b++) begin
               if ((int'(cnt[CW-1:3]) == l) && (int'(cnt[1:0]) == b)) begin
                  if (cnt[2]) begin
                     op_b[l*32 + b*8 +: 8] <= in_byte;
                  end else begin
                     op_a[l*32 + b*8 +: 8] <= in_byte;
                  end
               end
            end
         end
      end
   end

   // Result buffer: snapshot of the whole bank output in CAPTURE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rbuf <= '0;
      end else if (state == ST_CAPTURE) begin
         rbuf <= res;
      end
   end

   // Output byte mux; forced to zero outside DRAIN.
   always_comb begin
      out_byte = 8'h00;
      if (state == ST_DRAIN) begin
         for (int k = 0; k < OUT_BYTES; k++) begin
            if (int'(cnt) == k) begin
               out_byte = rbuf[k*8 +: 8];
            end
         end
      end
   end

`ifdef ADDER_BANK_CTRL_CHECK_EN
   logic [31:0] chk_a;
   logic [31:0] chk_b;
   logic [31:0] chk_r;
   logic [31:0] chk_sum;
   logic        err_q;

   // Select the lane under check and recompute it with one shared adder.
   always_comb begin
      chk_a = 32'h0;
      chk_b = 32'h0;
      chk_r = 32'h0;
      for (int l = 0; l < NUM_LANES; l++) begin
         if (int'(cnt) == l) begin
            chk_a = op_a[l*32 +: 32];
            chk_b = op_b[l*32 +: 32];
            chk_r = rbuf[l*32 +: 32];
         end
      end
      chk_sum = chk_a + chk_b;
   end

   // Sticky mismatch flag, cleared by the first byte of the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (in_fire && (cnt == '0)) begin
         err_q <= 1'b0;
      end else if ((state == ST_CHECK) && (chk_sum != chk_r)) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: doc/adder_bank_ctrl.md
# adder_bank_ctrl

- Byte-serial front end for the 10-lane, 32-bit carry-less (mod 2^32) adder bank.
- Accepts a frame of operand bytes over a valid/ready stream and drives the registered operands into the bank.
- Waits a fixed settle time, captures all lane sums, then streams them back out byte-serially.
- Makes the bank usable from the 8-bit Tiny Tapeout I/O and keeps bank paths registered on both sides.

## Interface
Parameters:
- NUM_LANES, 10, number of adder lanes driven; the bank width in every flattened bus is NUM_LANES*32.
- SETTLE_CYCLES, 2, whole cycles operands are held stable before capture; legal range 1–15.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_byte  in  8  operand byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  block accepts in_byte this cycle.
- out_byte  out  8  result byte.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  sink accepts out_byte this cycle.
- busy  out  1  high in every state except LOAD.
- err  out  1  sticky self-check mismatch; see Configuration.
- op_a  out  NUM_LANES*32  lane i operand a at [32i+31:32i], registered.
- op_b  out  NUM_LANES*32  lane i operand b, registered.
- res  in  NUM_LANES*32  lane sums returned from the adder bank.

## Operation
- Handshake: a transfer occurs on a cycle with valid && ready. A source may hold valid indefinitely. out_byte and out_valid must not change while out_valid=1 and out_ready=0.
- Input frame: 8*NUM_LANES bytes (80 by default).
  - Order: lane 0 a, lane 0 b, lane 1 a, … lane N-1 b.
  - Each word is little-endian: byte 0 = bits [7:0].
  - Each accepted byte is written directly into its op_a/op_b slice.
- Output frame: 4*NUM_LANES bytes (40 by default). Order is lane 0 sum … lane N-1 sum, each little-endian.
- Arithmetic is done by the bank, (a+b) mod 2^32. The carry-out is discarded and not reported.
- States:
  - LOAD: in_ready=1. Byte counter increments on each transfer. On the last byte → SETTLE, counter cleared.
  - SETTLE: in_ready=0. Count SETTLE_CYCLES cycles → CAPTURE.
  - CAPTURE: one cycle. Register all of res into the result buffer → CHECK if the macro is defined, else DRAIN.
  - CHECK (macro only): NUM_LANES cycles. Recompute one lane per cycle with an internal shared 32-bit adder and compare against the captured sum → DRAIN.
  - DRAIN: out_valid=1. Byte counter advances per output transfer. After the last byte → LOAD, counters cleared.
- op_a/op_b hold their values after the frame until overwritten byte-by-byte by the next frame. Partial-frame states are visible on the bank.
- The first input transfer of a frame clears err.
- Reset mid-operation: asynchronous return to LOAD. All registers and counters are cleared and any partial frame is discarded. No output byte may appear after rst_n falls.

## Timing
- Reset values: in_ready=1, out_valid=0, out_byte=0, busy=0, err=0, op_a=0, op_b=0. The result buffer and counters are also 0.
- Let cycle T be the cycle of the last input transfer. First out_valid=1 is at cycle T+SETTLE_CYCLES+2, or T+SETTLE_CYCLES+2+NUM_LANES with the check enabled.
- With out_ready held at 1, one byte transfers per cycle. in_ready rises the cycle after the last output transfer.
- in_ready and out_valid are never high in the same cycle; input and output frames do not overlap.
- busy rises the cycle after the last input transfer and falls the cycle after the last output transfer.

## Configuration
- ADDER_BANK_CTRL_CHECK_EN:
  - Defined: the CHECK state and the shared 32-bit checker adder are compiled in. err goes to 1 on any lane mismatch and stays 1 until the next frame's first input byte or reset.
  - Undefined: CHECK is skipped (CAPTURE → DRAIN) and err is tied to 0.

## Test plan
- Single frame, all lanes a=0x0000_0001, b=0x0000_0002, sink always ready → 40 bytes out, each lane 03 00 00 00. First out_valid at T+SETTLE_CYCLES+2 without the check.
- Wrap-around: lane 3 a=0xFFFF_FFFF, b=0x0000_0002 → lane 3 bytes 01 00 00 00. No carry visible anywhere, err=0.
- Backpressure: toggle out_ready 0/1 randomly, and gap in_valid every 3rd cycle → byte sequence identical to the no-stall run, and out_byte stable during every stall.
- Reset mid-DRAIN after 17 output bytes → out_valid=0, in_ready=1, op_a=op_b=0 immediately. The next full frame produces the correct 40 bytes.
- Check enabled, bench forces res lane 5 to 0xDEAD_BEEF ≠ expected → err=1 before the first output byte, stays 1 through DRAIN, and clears on the next frame's first input transfer.
